// File: rtl/mux_scan_if.sv
// Handshake bundle between the mux scan sequencer, its requester, the 8:1 mux
// and the downstream consumer of the packed result word.
interface mux_scan_if #(
   parameter int SEL_W = 3
);
   localparam int NCH = 2 ** SEL_W;

   logic             start;
   logic [NCH-1:0]   chan_mask;
   logic             mux_out;
   logic             ready;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             valid;
   logic [NCH-1:0]   data;

   modport master (
      output start, chan_mask, mux_out, ready,
      input  sel, busy, valid, data
   );

   modport slave (
      input  start, chan_mask, mux_out, ready,
      output sel, busy, valid, data
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks the mux select across the latched channel mask, dwelling DWELL cycles
// per channel, and packs the sampled bits into one word behind valid/ready.
//
// state   | meaning
// S_IDLE  | waiting for start, sel parked at 0
// S_DWELL | holding sel, counting down to the sample edge
// S_DONE  | result word valid, held until valid && ready
module mux_scan_ctrl #(
   parameter int SEL_W = 3,
   parameter int DWELL = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   mux_scan_if.slave bus_io
);
   localparam int NCH = 2 ** SEL_W;
   localparam logic [3:0] DWELL_LD = 4'(DWELL);

   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [NCH-1:0]   mask_q, mask_d;
   logic [NCH-1:0]   shadow_q, shadow_d;
   logic [NCH-1:0]   data_q, data_d;

   logic [SEL_W-1:0] first_sel, next_sel;
   logic             has_first, has_next;

   // Descending loops leave the lowest qualifying index in the result.
   always_comb begin
      first_sel = '0;
      has_first = 1'b0;
      next_sel  = '0;
      has_next  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (bus_io.chan_mask[i]) begin
            first_sel = SEL_W'(i);
            has_first = 1'b1;
         end
         if (mask_q[i] && (i > int'(sel_q))) begin
            next_sel = SEL_W'(i);
            has_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (bus_io.start) begin
               mask_d   = bus_io.chan_mask;
               shadow_d = '0;
               if (has_first) begin
                  sel_d   = first_sel;
                  cnt_d   = DWELL_LD;
                  state_d = S_DWELL;
               end else begin
                  data_d  = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DWELL: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               shadow_d[sel_q] = bus_io.mux_out;
               if (has_next) begin
                  sel_d = next_sel;
                  cnt_d = DWELL_LD;
               end else begin
                  data_d  = shadow_d;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus_io.ready) begin
               sel_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus_io.sel   = sel_q;
      bus_io.data  = data_q;
      bus_io.busy  = (state_q != S_IDLE);
      bus_io.valid = (state_q == S_DONE);
   end
endmodule
